wired_lsu_storebuf: RTL and testbench
=====================================

// Module: wired_lsu_storebuf
// PURPOSE
//  Speculative store buffer between LSU M1->M2 and the dcache data SRAM write port.
//  Stores enter when the M1-M2 handshake fires. The commit stage marks them
//  committed in program order. Committed cache-hit stores drain in order to the data
//  SRAM; committed miss/uncached heads are retired by commit via invalid_i.
//  All valid entries are exported for load forwarding. Tag snoops keep per-entry way-hit vectors current.
// PARAMETERS
//  DEPTH  4  entry count, power of 2, >=2
//  WAYS   4  dcache ways (width of hit/twe vectors)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous active-low reset
//  flush_i        in   1          pipeline flush: drop all uncommitted entries
//  push_valid_i   in   1          new store from M1 (M1-M2 handshake && wreq)
//  push_ready_o   out  1          buffer not full
//  push_paddr_i   in   32         physical address
//  push_hit_i     in   WAYS       one-hot write-hit way, 0 = miss/uncached
//  push_strb_i    in   4          byte strobe
//  push_wdata_i   in   32         write data
//  commit_i       in   1          commit oldest uncommitted entry
//  invalid_i      in   1          retire committed head without SRAM write
//  top_hit_o      out  1          head valid && |head.hit
//  dw_valid_o     out  1          SRAM write request (head committed && hit)
//  dw_ready_i     in   1          SRAM write accepted
//  dw_addr_o      out  12         head paddr[11:0] (word index = [11:2])
//  dw_way_o       out  WAYS       head hit vector
//  dw_strb_o      out  4          head strobe
//  dw_wdata_o     out  32         head data
//  ent_valid_o    out  DEPTH      per-slot valid, indexed by physical slot
//  ent_paddr_o    out  DEPTH*32   per-slot paddr
//  ent_strb_o     out  DEPTH*4    per-slot strobe
//  ent_wdata_o    out  DEPTH*32   per-slot data
//  snoop_taddr_i  in   12         tag-write index address (bits [11:4] compared)
//  snoop_twe_i    in   WAYS       per-way tag write enable
//  snoop_tag_p_i  in   WAYS*20    per-way new tag ppn
//  snoop_tag_wp_i in   WAYS       per-way new tag write permission
// BEHAVIOUR
//  - Storage is a circular FIFO. head, cmt, and tail pointers are log2(DEPTH)+1 bits
//    with a wrap bit. Invariant: head <= cmt <= tail. cnt = tail-head.
//    Full when cnt == DEPTH. Empty when cnt == 0.
//  - Reset: pointers=0, all valid/committed=0, push_ready_o=1, dw_valid_o=0, top_hit_o=0.
//  - Push: on push_valid_i && push_ready_o, write slot[tail] and tail++.
//    The entry is captured exactly as given; upstream has already applied the same-cycle snoop.
//  - push_ready_o = !full, computed from registered state only.
//    A same-cycle pop does not free space for a push (no pass-through).
//  - Commit: commit_i with cmt != tail -> committed[cmt]=1, cmt++. With cmt == tail, it is ignored.
//  - Drain: dw_valid_o = valid[head] && committed[head] && |hit[head], combinational from registers.
//    On dw_valid_o && dw_ready_i: clear valid[head], head++ (write latency 0; the SRAM writes that edge).
//  - invalid_i: pops head only if it is valid, committed, and hit==0. Otherwise it is ignored.
//    invalid_i and a drain never both fire.
//  - Flush: tail <= cmt. Valid is cleared for every slot in [cmt, tail). Committed entries stay and keep draining.
//    Push in the same cycle is discarded. Commit in the same cycle is applied first:
//    that entry survives, and the new tail is cmt+1.
//  - Snoop: for every valid entry with paddr[11:4] == snoop_taddr_i[11:4], for each way w with twe[w]:
//    hit[w] <= (tag_p[w] == paddr[31:12]) && tag_wp[w].
//    If the head is popped in the same cycle, the pop wins.
//    The snoop also updates dw_way_o for the next cycle.
//  - ent_* outputs are raw registers. Invalid slots may carry stale data; consumers qualify them with ent_valid_o.
//  - Reset mid-operation discards all entries, committed or not.
// TESTING
//  - Reset, then 4 pushes (paddr 0x1000,0x1004,0x1008,0x100C, hit=0001), no commit:
//    push_ready_o=0 after the 4th, ent_valid_o=1111, dw_valid_o=0.
//  - Commit 2, dw_ready_i=1: two writes, dw_addr_o 0x000 then 0x004, way 0001.
//    head=2, push_ready_o=1 after the first pop (registered).
//  - Entries A (committed, hit=0010) and B,C (uncommitted), then flush_i:
//    only A remains, and it drains. A same-cycle push is dropped and ent_valid_o shows only A.
//  - Head committed with hit=0000: top_hit_o=0, dw_valid_o=0. invalid_i pops it.
//    invalid_i on an uncommitted head has no effect.
//  - Entry paddr 0x8000_1230 hit=0000. Snoop taddr=0x230, twe=0100, tag_p[2]=0x80001, wp=1:
//    next cycle hit=0100, and after commit dw_valid_o=1 with way 0100.
//    A mismatching tag_p clears that way bit.
//  - Full buffer with drain and push in the same cycle: push rejected, drain succeeds,
//    and the next-cycle push is accepted.

Source files
------------

// File: rtl/wired_lsu_storebuf_if.sv
// Store-buffer bus bundle: the M1->M2 store push channel and the dcache data SRAM write channel.
// The slave modport is the store buffer's view; master is the LSU/SRAM side driving it.
interface wired_lsu_storebuf_if #(
    parameter int WAYS = 4
);
    logic            push_valid_i;
    logic            push_ready_o;
    logic [31:0]     push_paddr_i;
    logic [WAYS-1:0] push_hit_i;
    logic [3:0]      push_strb_i;
    logic [31:0]     push_wdata_i;

    logic            dw_valid_o;
    logic            dw_ready_i;
    logic [11:0]     dw_addr_o;
    logic [WAYS-1:0] dw_way_o;
    logic [3:0]      dw_strb_o;
    logic [31:0]     dw_wdata_o;

    modport slave (
        input  push_valid_i, push_paddr_i, push_hit_i, push_strb_i, push_wdata_i,
        output push_ready_o,
        output dw_valid_o, dw_addr_o, dw_way_o, dw_strb_o, dw_wdata_o,
        input  dw_ready_i
    );

    modport master (
        output push_valid_i, push_paddr_i, push_hit_i, push_strb_i, push_wdata_i,
        input  push_ready_o,
        input  dw_valid_o, dw_addr_o, dw_way_o, dw_strb_o, dw_wdata_o,
        output dw_ready_i
    );
endinterface

// File: rtl/wired_lsu_storebuf.sv
// Speculative store buffer: circular FIFO with head/commit/tail pointers, in-order drain
// of committed hit stores to the dcache data SRAM, flush of uncommitted entries and tag snooping.
module wired_lsu_storebuf #(
    parameter int DEPTH = 4,
    parameter int WAYS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 commit_i,
    input  logic                 invalid_i,
    output logic                 top_hit_o,
    output logic [DEPTH-1:0]     ent_valid_o,
    output logic [DEPTH*32-1:0]  ent_paddr_o,
    output logic [DEPTH*4-1:0]   ent_strb_o,
    output logic [DEPTH*32-1:0]  ent_wdata_o,
    input  logic [11:0]          snoop_taddr_i,
    input  logic [WAYS-1:0]      snoop_twe_i,
    input  logic [WAYS*20-1:0]   snoop_tag_p_i,
    input  logic [WAYS-1:0]      snoop_tag_wp_i,
    wired_lsu_storebuf_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] ptr_t;
    localparam ptr_t FULL_CNT = ptr_t'(DEPTH);

    ptr_t head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            committed_q, committed_d;
    logic [DEPTH-1:0][31:0]      paddr_q, paddr_d;
    logic [DEPTH-1:0][WAYS-1:0]  hit_q, hit_d;
    logic [DEPTH-1:0][3:0]       strb_q, strb_d;
    logic [DEPTH-1:0][31:0]      wdata_q, wdata_d;

    logic [PW-1:0] head_idx, cmt_idx, tail_idx;
    ptr_t          cnt;
    logic          full;
    logic          head_hit;
    logic          drain_fire, inv_fire, pop_fire, commit_fire, push_fire;
    ptr_t          keep_ptr, span, slot_ptr;

    // Only the snoop index bits [11:4] select entries; the word offset is irrelevant.
    logic unused_taddr;
    assign unused_taddr = ^snoop_taddr_i[3:0];

    assign head_idx = head_q[PW-1:0];
    assign cmt_idx  = cmt_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];
    assign cnt      = tail_q - head_q;
    assign full     = (cnt == FULL_CNT);
    assign head_hit = |hit_q[head_idx];

    assign sb.push_ready_o = !full;
    assign top_hit_o       = valid_q[head_idx] && head_hit;
    assign sb.dw_valid_o   = valid_q[head_idx] && committed_q[head_idx] && head_hit;
    assign sb.dw_addr_o    = paddr_q[head_idx][11:0];
    assign sb.dw_way_o     = hit_q[head_idx];
    assign sb.dw_strb_o    = strb_q[head_idx];
    assign sb.dw_wdata_o   = wdata_q[head_idx];

    assign drain_fire  = sb.dw_valid_o && sb.dw_ready_i;
    assign inv_fire    = invalid_i && valid_q[head_idx] && committed_q[head_idx] && !head_hit;
    assign pop_fire    = drain_fire || inv_fire;
    assign commit_fire = commit_i && (cmt_q != tail_q);
    assign push_fire   = sb.push_valid_i && !full && !flush_i;

    always_comb begin
        head_d      = head_q;
        cmt_d       = cmt_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        paddr_d     = paddr_q;
        hit_d       = hit_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        keep_ptr    = commit_fire ? cmt_q + ptr_t'(1) : cmt_q;
        span        = tail_q - keep_ptr;
        slot_ptr    = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (paddr_q[i][11:4] == snoop_taddr_i[11:4])) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (snoop_twe_i[w]) begin
                        hit_d[i][w] = (snoop_tag_p_i[w*20 +: 20] == paddr_q[i][31:12])
                                      && snoop_tag_wp_i[w];
                    end
                end
            end
        end

        // Applied after the snoop so a same-cycle pop leaves the slot empty.
        if (pop_fire) begin
            valid_d[head_idx]     = 1'b0;
            committed_d[head_idx] = 1'b0;
            head_d                = head_q + ptr_t'(1);
        end

        if (commit_fire) begin
            committed_d[cmt_idx] = 1'b1;
            cmt_d                = cmt_q + ptr_t'(1);
        end

        if (push_fire) begin
            valid_d[tail_idx]     = 1'b1;
            committed_d[tail_idx] = 1'b0;
            paddr_d[tail_idx]     = sb.push_paddr_i;
            hit_d[tail_idx]       = sb.push_hit_i;
            strb_d[tail_idx]      = sb.push_strb_i;
            wdata_d[tail_idx]     = sb.push_wdata_i;
            tail_d                = tail_q + ptr_t'(1);
        end

        // Flush keeps everything up to (and including) a same-cycle commit.
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_ptr = keep_ptr + ptr_t'(k);
                if (ptr_t'(k) < span) begin
                    valid_d[slot_ptr[PW-1:0]]     = 1'b0;
                    committed_d[slot_ptr[PW-1:0]] = 1'b0;
                end
            end
            tail_d = keep_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            cmt_q       <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            committed_q <= '0;
        end else begin
            head_q      <= head_d;
            cmt_q       <= cmt_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
        end
    end

    // Payload is always qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        paddr_q <= paddr_d;
        hit_q   <= hit_d;
        strb_q  <= strb_d;
        wdata_q <= wdata_d;
    end

    assign ent_valid_o = valid_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        assign ent_paddr_o[gi*32 +: 32] = paddr_q[gi];
        assign ent_strb_o[gi*4 +: 4]    = strb_q[gi];
        assign ent_wdata_o[gi*32 +: 32] = wdata_q[gi];
    end
endmodule

// File: tb/tb_wired_lsu_storebuf.sv
// Directed testbench for wired_lsu_storebuf: one task per scenario with inline comparisons
// against hand-computed expected values.
module tb_wired_lsu_storebuf;
    localparam int DEPTH = 4;
    localparam int WAYS  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush_i, commit_i, invalid_i;
    logic               top_hit_o;
    logic [DEPTH-1:0]   ent_valid_o;
    logic [DEPTH*32-1:0] ent_paddr_o;
    logic [DEPTH*4-1:0] ent_strb_o;
    logic [DEPTH*32-1:0] ent_wdata_o;
    logic [11:0]        snoop_taddr_i;
    logic [WAYS-1:0]    snoop_twe_i;
    logic [WAYS*20-1:0] snoop_tag_p_i;
    logic [WAYS-1:0]    snoop_tag_wp_i;

    int n_cmp = 0;
    int n_err = 0;

    wired_lsu_storebuf_if #(.WAYS(WAYS)) sb ();

    wired_lsu_storebuf #(.DEPTH(DEPTH), .WAYS(WAYS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .commit_i       (commit_i),
        .invalid_i      (invalid_i),
        .top_hit_o      (top_hit_o),
        .ent_valid_o    (ent_valid_o),
        .ent_paddr_o    (ent_paddr_o),
        .ent_strb_o     (ent_strb_o),
        .ent_wdata_o    (ent_wdata_o),
        .snoop_taddr_i  (snoop_taddr_i),
        .snoop_twe_i    (snoop_twe_i),
        .snoop_tag_p_i  (snoop_tag_p_i),
        .snoop_tag_wp_i (snoop_tag_wp_i),
        .sb             (sb)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 1'b0; commit_i = 1'b0; invalid_i = 1'b0;
        sb.push_valid_i = 1'b0; sb.push_paddr_i = '0; sb.push_hit_i = '0;
        sb.push_strb_i = '0; sb.push_wdata_i = '0; sb.dw_ready_i = 1'b0;
        snoop_taddr_i = '0; snoop_twe_i = '0; snoop_tag_p_i = '0; snoop_tag_wp_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_push(input logic [31:0] addr, input logic [3:0] hit,
                            input logic [3:0] strb, input logic [31:0] data);
        sb.push_valid_i = 1'b1; sb.push_paddr_i = addr; sb.push_hit_i = hit;
        sb.push_strb_i = strb; sb.push_wdata_i = data;
        $display("push addr=%08h hit=%b strb=%h data=%08h", addr, hit, strb, data);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (sb.push_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b want=1", sb.push_ready_o); end
        n_cmp++; if (sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_dw_valid got=%b want=0", sb.dw_valid_o); end
        n_cmp++; if (top_hit_o !== 1'b0) begin n_err++; $display("FAIL rst_top_hit got=%b want=0", top_hit_o); end
        n_cmp++; if (ent_valid_o !== 4'b0000) begin n_err++; $display("FAIL rst_ent_valid got=%b want=0000", ent_valid_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(i * 4), 4'b0001, (i == 1) ? 4'h3 : 4'hF, 32'hA000_0000 + 32'(i));
            step();
        end
        sb.push_valid_i = 1'b0;
        n_cmp++; if (sb.push_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%b want=0", sb.push_ready_o); end
        n_cmp++; if (ent_valid_o !== 4'b1111) begin n_err++; $display("FAIL fill_ent_valid got=%b want=1111", ent_valid_o); end
        n_cmp++; if (sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL fill_dw_valid got=%b want=0", sb.dw_valid_o); end
        n_cmp++; if (top_hit_o !== 1'b1) begin n_err++; $display("FAIL fill_top_hit got=%b want=1", top_hit_o); end
        n_cmp++; if (ent_strb_o !== 16'hFF3F) begin n_err++; $display("FAIL fill_ent_strb got=%h want=ff3f", ent_strb_o); end
        n_cmp++; if (ent_wdata_o[127:96] !== 32'hA000_0003) begin n_err++; $display("FAIL fill_ent_wdata3 got=%h want=a0000003", ent_wdata_o[127:96]); end
        n_cmp++; if (ent_paddr_o[95:64] !== 32'h0000_1008) begin n_err++; $display("FAIL fill_ent_paddr2 got=%h want=00001008", ent_paddr_o[95:64]); end
    endtask

    task automatic test_commit_drain();
        commit_i = 1'b1;
        step();
        step();
        commit_i = 1'b0;
        n_cmp++; if (sb.dw_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid0 got=%b want=1", sb.dw_valid_o); end
        n_cmp++; if (sb.dw_addr_o !== 12'h000) begin n_err++; $display("FAIL drain_addr0 got=%h want=000", sb.dw_addr_o); end
        n_cmp++; if (sb.dw_way_o !== 4'b0001) begin n_err++; $display("FAIL drain_way0 got=%b want=0001", sb.dw_way_o); end
        n_cmp++; if (sb.dw_wdata_o !== 32'hA000_0000) begin n_err++; $display("FAIL drain_wdata0 got=%h want=a0000000", sb.dw_wdata_o); end
        sb.dw_ready_i = 1'b1;
        step();
        $display("drain write addr=000");
        n_cmp++; if (ent_valid_o !== 4'b1110) begin n_err++; $display("FAIL drain_ent_valid1 got=%b want=1110", ent_valid_o); end
        n_cmp++; if (sb.push_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_ready1 got=%b want=1", sb.push_ready_o); end
        n_cmp++; if (sb.dw_addr_o !== 12'h004) begin n_err++; $display("FAIL drain_addr1 got=%h want=004", sb.dw_addr_o); end
        n_cmp++; if (sb.dw_strb_o !== 4'h3) begin n_err++; $display("FAIL drain_strb1 got=%h want=3", sb.dw_strb_o); end
        step();
        $display("drain write addr=004");
        sb.dw_ready_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b1100) begin n_err++; $display("FAIL drain_ent_valid2 got=%b want=1100", ent_valid_o); end
        n_cmp++; if (sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_uncommitted got=%b want=0", sb.dw_valid_o); end
    endtask

    task automatic test_flush();
        apply_reset();
        set_push(32'h0000_2000, 4'b0010, 4'hF, 32'h1111_1111);   // A -> slot 0
        step();
        set_push(32'h0000_2004, 4'b0001, 4'hF, 32'h2222_2222);   // B -> slot 1
        commit_i = 1'b1;                                         // commit A
        step();
        commit_i = 1'b0;
        set_push(32'h0000_2008, 4'b0001, 4'hF, 32'h3333_3333);   // C -> slot 2
        step();
        set_push(32'h0000_200C, 4'b0001, 4'hF, 32'h4444_4444);   // D, dropped by flush
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; sb.push_valid_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0001) begin n_err++; $display("FAIL flush_ent_valid got=%b want=0001", ent_valid_o); end
        n_cmp++; if (sb.dw_valid_o !== 1'b1) begin n_err++; $display("FAIL flush_dw_valid got=%b want=1", sb.dw_valid_o); end
        n_cmp++; if (sb.dw_way_o !== 4'b0010) begin n_err++; $display("FAIL flush_dw_way got=%b want=0010", sb.dw_way_o); end
        sb.dw_ready_i = 1'b1;
        step();
        sb.dw_ready_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0000) begin n_err++; $display("FAIL flush_drained got=%b want=0000", ent_valid_o); end

        // Flush with a same-cycle commit keeps the newly committed entry.
        set_push(32'h0000_3004, 4'b0001, 4'hF, 32'h5555_5555);   // slot 1
        step();
        set_push(32'h0000_3008, 4'b0001, 4'hF, 32'h6666_6666);   // slot 2
        step();
        sb.push_valid_i = 1'b0;
        commit_i = 1'b1; flush_i = 1'b1;
        step();
        commit_i = 1'b0; flush_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0010) begin n_err++; $display("FAIL flushcmt_ent_valid got=%b want=0010", ent_valid_o); end
        n_cmp++; if (sb.dw_valid_o !== 1'b1 || sb.dw_addr_o !== 12'h004) begin n_err++; $display("FAIL flushcmt_dw got=%b/%h want=1/004", sb.dw_valid_o, sb.dw_addr_o); end
        sb.dw_ready_i = 1'b1;
        step();
        sb.dw_ready_i = 1'b0;
        set_push(32'h0000_300C, 4'b0001, 4'hF, 32'h7777_7777);   // lands in slot 2
        step();
        sb.push_valid_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0100) begin n_err++; $display("FAIL flushcmt_next_slot got=%b want=0100", ent_valid_o); end
    endtask

    task automatic test_invalid();
        apply_reset();
        set_push(32'h0000_4010, 4'b0000, 4'hF, 32'hDEAD_BEEF);
        step();
        sb.push_valid_i = 1'b0;
        n_cmp++; if (top_hit_o !== 1'b0 || sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL inv_miss_head got=%b/%b want=0/0", top_hit_o, sb.dw_valid_o); end
        invalid_i = 1'b1;
        step();
        invalid_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0001) begin n_err++; $display("FAIL inv_uncommitted got=%b want=0001", ent_valid_o); end
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        n_cmp++; if (sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL inv_committed_miss_dw got=%b want=0", sb.dw_valid_o); end
        invalid_i = 1'b1;
        step();
        invalid_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b0000) begin n_err++; $display("FAIL inv_pop got=%b want=0000", ent_valid_o); end
        // Commit on an empty buffer is ignored, so the next entry stays uncommitted.
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        set_push(32'h0000_4020, 4'b0001, 4'hF, 32'h0);
        step();
        sb.push_valid_i = 1'b0;
        n_cmp++; if (sb.dw_valid_o !== 1'b0 || top_hit_o !== 1'b1) begin n_err++; $display("FAIL empty_commit_ignored got=%b/%b want=0/1", sb.dw_valid_o, top_hit_o); end
    endtask

    task automatic test_snoop();
        apply_reset();
        set_push(32'h8000_1230, 4'b0000, 4'hF, 32'hCAFE_0001);
        step();
        sb.push_valid_i = 1'b0;
        snoop_taddr_i = 12'h230; snoop_twe_i = 4'b0100;
        snoop_tag_p_i = {20'h0, 20'h80001, 20'h0, 20'h0}; snoop_tag_wp_i = 4'b0100;
        step();
        snoop_twe_i = '0;
        n_cmp++; if (top_hit_o !== 1'b1 || sb.dw_way_o !== 4'b0100) begin n_err++; $display("FAIL snoop_set got=%b/%b want=1/0100", top_hit_o, sb.dw_way_o); end
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        n_cmp++; if (sb.dw_valid_o !== 1'b1 || sb.dw_way_o !== 4'b0100) begin n_err++; $display("FAIL snoop_commit_dw got=%b/%b want=1/0100", sb.dw_valid_o, sb.dw_way_o); end
        // Different index: mismatching tag must not touch the entry.
        snoop_taddr_i = 12'h240; snoop_twe_i = 4'b0100;
        snoop_tag_p_i = {20'h0, 20'h80002, 20'h0, 20'h0};
        step();
        n_cmp++; if (sb.dw_way_o !== 4'b0100) begin n_err++; $display("FAIL snoop_other_index got=%b want=0100", sb.dw_way_o); end
        snoop_taddr_i = 12'h234;
        step();
        snoop_twe_i = '0;
        n_cmp++; if (sb.dw_way_o !== 4'b0000 || sb.dw_valid_o !== 1'b0) begin n_err++; $display("FAIL snoop_clear got=%b/%b want=0000/0", sb.dw_way_o, sb.dw_valid_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h0000_5000 + 32'(i * 4), 4'b0001, 4'hF, 32'hB000_0000 + 32'(i));
            step();
        end
        sb.push_valid_i = 1'b0;
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        set_push(32'h0000_6000, 4'b1000, 4'hF, 32'hC000_0000);
        sb.dw_ready_i = 1'b1;
        step();
        sb.dw_ready_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b1110) begin n_err++; $display("FAIL b2b_push_rejected got=%b want=1110", ent_valid_o); end
        n_cmp++; if (sb.push_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b want=1", sb.push_ready_o); end
        step();
        sb.push_valid_i = 1'b0;
        n_cmp++; if (ent_valid_o !== 4'b1111 || ent_paddr_o[31:0] !== 32'h0000_6000) begin n_err++; $display("FAIL b2b_push_accepted got=%b/%h want=1111/00006000", ent_valid_o, ent_paddr_o[31:0]); end
        n_cmp++; if (sb.push_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full_again got=%b want=0", sb.push_ready_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_fill();
        test_commit_drain();
        test_flush();
        test_invalid();
        test_snoop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
